// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache line bursts onto one memory port.
// ARB_ROUND_ROBIN_EN selects round-robin ties; default is fixed D-cache priority.
module cache_mem_arbiter #(
  parameter int OFFSET = 3,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_valid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [31:0]       dc_wdata,
  output logic              dc_wready,
  output logic              dc_valid,
  output logic              dc_done,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] MASK =
    {{(ADDR_W-OFFSET-2){1'b1}}, {(OFFSET+2){1'b0}}};

  state_t            state, state_n;
  logic              gnt_d, we_l, ptr;
  logic              ic_v, dc_v;
  logic              sel_d, last, burst;
  logic [ADDR_W-1:0] base;
  logic [OFFSET-1:0] beat;
  logic [31:0]       rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  assign sel_d = dc_req & (~ic_req | ptr);
`else
  assign sel_d = dc_req;
`endif

  assign last  = &beat;
  assign burst = (state == BURST);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (ic_req || dc_req) state_n = BURST;
      BURST:   if (mem_ack && last) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      beat    <= '0;
      ptr     <= 1'b1;
      gnt_d   <= 1'b0;
      we_l    <= 1'b0;
      base    <= '0;
      rdata_q <= '0;
      ic_v    <= 1'b0;
      dc_v    <= 1'b0;
    end else begin
      state <= state_n;
      ic_v  <= 1'b0;
      dc_v  <= 1'b0;
      if (state == IDLE && (ic_req || dc_req)) begin
        gnt_d <= sel_d;
        we_l  <= sel_d & dc_we;
        base  <= (sel_d ? dc_addr : ic_addr) & MASK;
        beat  <= '0;
      end
      if (burst && mem_ack) begin
        beat <= beat + 1'b1;
        if (!we_l) begin
          rdata_q <= mem_rdata;
          ic_v    <= ~gnt_d;
          dc_v    <= gnt_d;
        end
      end
      // The side just served loses the next tie.
      if (state == FINISH) ptr <= ~gnt_d;
    end
  end

  assign mem_req   = burst;
  assign mem_we    = burst & we_l;
  assign mem_addr  = burst ? base + ADDR_W'({beat, 2'b00}) : '0;
  assign mem_wdata = (burst && we_l) ? dc_wdata : '0;
  assign dc_wready = burst & we_l & mem_ack;
  assign ic_done   = (state == FINISH) & ~gnt_d;
  assign dc_done   = (state == FINISH) & gnt_d;
  assign ic_valid  = ic_v;
  assign dc_valid  = dc_v;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized self-checking bench for cache_mem_arbiter (OFFSET=3).
module tb_cache_mem_arbiter;

  localparam int OFFSET = 3;
  localparam int ADDR_W = 32;
  localparam int BEATS  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req, dc_req, dc_we;
  logic [31:0] ic_addr, dc_addr, dc_wdata;
  logic        ic_valid, ic_done, dc_valid, dc_done, dc_wready;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ack;

  int vectors = 0;
  int errors  = 0;
  bit ptr_d   = 1'b1;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.OFFSET(OFFSET), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_valid(ic_valid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_wready(dc_wready),
    .dc_valid(dc_valid), .dc_done(dc_done),
    .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit pick_d(input bit ic, input bit dc);
    if (!ic) return 1'b1;
    if (!dc) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return ptr_d;
`else
    return 1'b1;
`endif
  endfunction

  // Starts at a negedge with the request already raised; returns at a negedge.
  task automatic do_burst(input bit d, input bit keep, input int mode);
    logic [31:0] base, ea, ew;
    logic [31:0] wbuf [BEATS];
    bit we, pend, ack, last_prev, done_seen;
    int beats;
    base = (d ? dc_addr : ic_addr) & ~32'h1F;
    we = d & dc_we;
    for (int k = 0; k < BEATS; k++) wbuf[k] = $urandom;
    pend = 0; beats = 0; last_prev = 0; done_seen = 0; ew = '0;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      vectors++;
      if (ic_valid !== (pend && !d) || dc_valid !== (pend && d) ||
          (pend && rdata !== ew)) begin
        errors++;
        $display("FAIL valid: ic_valid=%b dc_valid=%b rdata=%h, required pend=%b d=%b rdata=%h",
                 ic_valid, dc_valid, rdata, pend, d, ew);
      end
      vectors++;
      if (ic_done !== (last_prev && !d) || dc_done !== (last_prev && d)) begin
        errors++;
        $display("FAIL done: ic_done=%b dc_done=%b, required last=%b d=%b beats=%0d",
                 ic_done, dc_done, last_prev, d, beats);
      end
      if (last_prev) begin
        done_seen = 1;
        ptr_d = !d;
        if (!keep) begin
          if (d) dc_req = 0;
          else ic_req = 0;
        end
      end
      last_prev = 0;
      pend = 0;
      ack = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      if (!done_seen && mem_req === 1'b1) begin
        ea = base + 32'(beats) * 4;
        dc_wdata = wbuf[beats % BEATS];
        mem_ack = ack;
        mem_rdata = memf(mem_addr);
        #1;
        vectors++;
        if (mem_addr !== ea || mem_we !== we || dc_wready !== (ack && we) ||
            (we && mem_wdata !== wbuf[beats % BEATS])) begin
          errors++;
          $display("FAIL beat%0d: addr=%h we=%b wready=%b wdata=%h, required addr=%h we=%b wready=%b wdata=%h",
                   beats, mem_addr, mem_we, dc_wready, mem_wdata,
                   ea, we, ack && we, wbuf[beats % BEATS]);
        end
        if (ack) begin
          beats++;
          pend = !we;
          ew = memf(ea);
          last_prev = (beats == BEATS);
        end
      end else begin
        mem_ack = ack;
        mem_rdata = $urandom;
      end
      @(negedge clk);
      mem_ack = 0;
    end
    if (!done_seen) begin
      errors++;
      $display("FAIL timeout: beats=%0d, required done after %0d beats", beats, BEATS);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    ic_req = 1; ic_addr = $urandom;
    dc_req = 1; dc_we = 1; dc_addr = $urandom; dc_wdata = $urandom;
    mem_ack = 1; mem_rdata = $urandom;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, rdata, ic_valid, ic_done,
         dc_valid, dc_done, dc_wready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h rdata=%h wready=%b, required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, rdata, dc_wready);
    end
    ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
    ptr_d = 1;
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_refill();
    ic_addr = 32'h0000_1234;
    ic_req = 1;
    do_burst(pick_d(1, 0), 0, 0);
    for (int i = 0; i < 3; i++) begin
      ic_addr = $urandom;
      ic_req = 1;
      do_burst(pick_d(1, 0), 0, 2);
    end
  endtask

  task automatic test_writeback();
    dc_addr = 32'h0000_0040;
    dc_we = 1;
    dc_req = 1;
    do_burst(pick_d(0, 1), 0, 1);
    dc_addr = $urandom; dc_we = 0; dc_req = 1;
    do_burst(pick_d(0, 1), 0, 2);
  endtask

  task automatic test_tie();
    bit d;
    ic_addr = $urandom; dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1));
    ic_req = 1; dc_req = 1;
    d = pick_d(1, 1);
    do_burst(d, 0, 2);
    do_burst(!d, 0, 2);
  endtask

  task automatic test_back_to_back();
    reset = 1;
    @(negedge clk);
    reset = 0; ptr_d = 1;
    ic_addr = $urandom; dc_addr = $urandom; dc_we = 0;
    ic_req = 1; dc_req = 1;
    for (int i = 0; i < 3; i++) do_burst(pick_d(1, 1), 1, 2);
    ic_req = 0; dc_req = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ic, dc, d;
    for (int i = 0; i < 6; i++) begin
      ic = 1'($urandom_range(0, 1));
      dc = 1'($urandom_range(0, 1));
      if (!ic && !dc) dc = 1;
      ic_addr = $urandom; dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1));
      ic_req = ic; dc_req = dc;
      d = pick_d(ic, dc);
      do_burst(d, 0, 2);
      if (ic && dc) do_burst(!d, 0, 2);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    ic_addr = $urandom;
    ic_req = 1;
    n = 0;
    for (int c = 0; c < 50 && n < 4; c++) begin
      if (mem_req === 1'b1) begin
        mem_ack = 1; mem_rdata = $urandom; n++;
      end else begin
        mem_ack = 0;
      end
      @(negedge clk);
    end
    mem_ack = 0;
    vectors++;
    if (n != 4 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: beats=%0d mem_req=%b, required 4 and 1", n, mem_req);
    end
    reset = 1;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, rdata, ic_valid, ic_done,
         dc_valid, dc_done, dc_wready} !== '0) begin
      errors++;
      $display("FAIL mid_reset: req=%b addr=%h rdata=%h ic_valid=%b ic_done=%b, required all 0",
               mem_req, mem_addr, rdata, ic_valid, ic_done);
    end
    @(negedge clk);
    vectors++;
    if (ic_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_nodone: ic_done=%b mem_req=%b, required 0 0", ic_done, mem_req);
    end
    reset = 0; ptr_d = 1;
    do_burst(pick_d(1, 0), 0, 0);
  endtask

  initial begin
    test_reset();
    test_refill();
    test_writeback();
    test_tie();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
